// File: rtl/rv_decode_unit_pkg.sv
// Shared opcode constants and control-field encodings for the RV32I-subset decode stage.
package rv_decode_unit_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // isSub is only ever true for R-type with funct7b5; I-type has no subi.
    function automatic alu_ctrl_e aluDecode(input logic [2:0] funct3, input logic isSub);
        case (funct3)
            3'b000:  return isSub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_unit_regfile.sv
// Register file with asynchronous reads, x0 hard-wired to zero and synchronous clear.
// Optional write-first bypass when RF_BYPASS_EN is defined.
module rv_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            writeValid;
    logic            bypass1;
    logic            bypass2;

    assign writeValid = WE3 && (A3 != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeValid) begin
            regs[A3] <= WD3;
        end
    end

`ifdef RF_BYPASS_EN
    assign bypass1 = !rst && writeValid && (A3 == A1);
    assign bypass2 = !rst && writeValid && (A3 == A2);
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    assign RD1 = (A1 == '0) ? '0 : (bypass1 ? WD3 : regs[A1]);
    assign RD2 = (A2 == '0) ? '0 : (bypass2 ? WD3 : regs[A2]);

endmodule

// File: rtl/rv_decode_unit.sv
// Decode stage: instruction decoder, immediate extender and 32x32 register file.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rv_decode_unit
    import rv_decode_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     Instr,
    input  logic            WE3,
    input  logic [4:0]      A3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic [4:0]      Rs1,
    output logic [4:0]      Rs2,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] ImmExt,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            Jump,
    output logic            Branch,
    output logic            ALUSrc,
    output logic [1:0]      ResultSrc,
    output logic [2:0]      ALUControl,
    output logic [1:0]      ImmSrc,
    output logic            ByteAddress,
    output logic            ReadEnable
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [24:0] inp;
    logic        sgn;
    alu_ctrl_e   aluCtrl;
    imm_src_e    immSel;
    result_src_e resSel;

    assign opcode   = Instr[6:0];
    assign funct3   = Instr[14:12];
    assign funct7b5 = Instr[30];
    assign inp      = Instr[31:7];
    assign sgn      = inp[24];

    assign Rs1 = Instr[19:15];
    assign Rs2 = Instr[24:20];
    assign Rd  = Instr[11:7];

    always_comb begin
        RegWrite    = 1'b0;
        MemWrite    = 1'b0;
        Jump        = 1'b0;
        Branch      = 1'b0;
        ALUSrc      = 1'b0;
        ReadEnable  = 1'b0;
        ByteAddress = 1'b0;
        resSel      = RES_ALU;
        immSel      = IMM_I;
        aluCtrl     = ALU_ADD;
        case (opcode)
            OP_LOAD: begin
                RegWrite    = 1'b1;
                ALUSrc      = 1'b1;
                resSel      = RES_MEM;
                ReadEnable  = 1'b1;
                ByteAddress = (funct3 == 3'b000);
            end
            OP_STORE: begin
                MemWrite    = 1'b1;
                immSel      = IMM_S;
                ALUSrc      = 1'b1;
                ByteAddress = (funct3 == 3'b000);
            end
            OP_R: begin
                RegWrite = 1'b1;
                aluCtrl  = aluDecode(funct3, funct7b5);
            end
            OP_I: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                aluCtrl  = aluDecode(funct3, 1'b0);
            end
            OP_BRANCH: begin
                Branch  = 1'b1;
                immSel  = IMM_B;
                aluCtrl = ALU_SUB;
            end
            OP_JAL: begin
                RegWrite = 1'b1;
                Jump     = 1'b1;
                immSel   = IMM_J;
                resSel   = RES_PC4;
            end
            default: ;
        endcase
    end

    assign ALUControl = aluCtrl;
    assign ImmSrc     = immSel;
    assign ResultSrc  = resSel;

    always_comb begin
        case (immSel)
            IMM_S:   ImmExt = {{(XLEN-12){sgn}}, inp[24:18], inp[4:0]};
            IMM_B:   ImmExt = {{(XLEN-12){sgn}}, inp[0], inp[23:18], inp[4:1], 1'b0};
            IMM_J:   ImmExt = {{(XLEN-20){sgn}}, inp[12:5], inp[13], inp[23:14], 1'b0};
            default: ImmExt = {{(XLEN-12){sgn}}, inp[24:13]};
        endcase
    end

    rv_regfile #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .AW   (5)
    ) uRegfile (
        .clk(clk),
        .rst(rst),
        .A1 (Rs1),
        .A2 (Rs2),
        .A3 (A3),
        .WE3(WE3),
        .WD3(WD3),
        .RD1(RD1),
        .RD2(RD2)
    );

endmodule

// File: tb/tb_rv_decode_unit.sv
// Self-checking bench for rv_decode_unit: instruction-level decode model plus register-file model.
module tb_rv_decode_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instr;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2, ImmExt;
    logic [4:0]  Rs1, Rs2, Rd;
    logic        RegWrite, MemWrite, Jump, Branch, ALUSrc, ByteAddress, ReadEnable;
    logic [1:0]  ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic        started = 1'b0;
    logic [31:0] mregs [32];

    always #5 clk = ~clk;

    rv_decode_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .WE3(WE3), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .ImmExt(ImmExt),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Jump(Jump), .Branch(Branch),
        .ALUSrc(ALUSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .ByteAddress(ByteAddress), .ReadEnable(ReadEnable)
    );

    typedef struct {
        logic        rw, mw, jmp, br, asrc, byteA, re;
        logic [1:0]  res, imm;
        logic [2:0]  alu;
        logic [31:0] immVal;
    } dec_t;

    // Decode expectations from the instruction-set view: mnemonic class, then standard RISC-V field layout.
    function automatic dec_t expDecode(input logic [31:0] ins);
        dec_t d;
        logic [2:0] f3;
        d = '{default: '0};
        f3 = ins[14:12];
        case (ins[6:0])
            7'h03: begin d.rw = 1; d.asrc = 1; d.res = 2'd1; d.re = 1; d.byteA = (f3 == 0); end
            7'h23: begin d.mw = 1; d.imm = 2'd1; d.asrc = 1; d.byteA = (f3 == 0); end
            7'h33, 7'h13: begin
                d.rw = 1;
                d.asrc = (ins[6:0] == 7'h13);
                if (f3 == 3'd2) d.alu = 3'b101;
                else if (f3 == 3'd6) d.alu = 3'b011;
                else if (f3 == 3'd7) d.alu = 3'b010;
                else if (f3 == 3'd0 && ins[6:0] == 7'h33 && ins[30]) d.alu = 3'b001;
            end
            7'h63: begin d.br = 1; d.imm = 2'd2; d.alu = 3'b001; end
            7'h6F: begin d.rw = 1; d.jmp = 1; d.imm = 2'd3; d.res = 2'd2; end
            default: ;
        endcase
        case (d.imm)
            2'd1: d.immVal = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            2'd2: d.immVal = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            2'd3: d.immVal = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            default: d.immVal = {{20{ins[31]}}, ins[31:20]};
        endcase
        return d;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (!rst && WE3 && A3 != 0 && A3 == idx) return WD3;
`endif
        return mregs[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else if (WE3 && A3 != 0) begin
            mregs[A3] = WD3;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            dec_t d;
            d = expDecode(Instr);
            check("RD1", RD1, expRead(Instr[19:15]));
            check("RD2", RD2, expRead(Instr[24:20]));
            check("Rs1", {27'd0, Rs1}, {27'd0, Instr[19:15]});
            check("Rs2", {27'd0, Rs2}, {27'd0, Instr[24:20]});
            check("Rd", {27'd0, Rd}, {27'd0, Instr[11:7]});
            check("ImmExt", ImmExt, d.immVal);
            check("ctrl", {25'd0, RegWrite, MemWrite, Jump, Branch, ALUSrc, ByteAddress, ReadEnable},
                  {25'd0, d.rw, d.mw, d.jmp, d.br, d.asrc, d.byteA, d.re});
            check("ResultSrc", {30'd0, ResultSrc}, {30'd0, d.res});
            check("ImmSrc", {30'd0, ImmSrc}, {30'd0, d.imm});
            check("ALUControl", {29'd0, ALUControl}, {29'd0, d.alu});
        end
    end

    task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic r);
        @(posedge clk);
        #2;
        Instr = ins; WE3 = we; A3 = a3; WD3 = wd; rst = r;
        #1;
    endtask

    function automatic logic [31:0] rAdd(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'h33};
    endfunction

    logic [31:0] extra [10] = '{
        32'h002081B3, 32'h0020E1B3, 32'h0020F1B3, 32'h0020A1B3, 32'h4070F093,
        32'h8000E093, 32'hFFF0A093, 32'h00000037, 32'h00208023, 32'h0000A183
    };

    initial begin
        rst = 1; WE3 = 0; A3 = 0; WD3 = 0; Instr = 0;
        @(posedge clk);
        #2 started = 1;
        drive(32'h00028013, 0, 0, 0, 0);
        check("reset_x5", RD1, 32'h0);

        drive(32'h00500093, 0, 0, 0, 0);
        check("addi_ctrl", {RegWrite, ALUSrc, ImmSrc, ALUControl}, {1'b1, 1'b1, 2'b00, 3'b000});
        check("addi_imm", ImmExt, 32'd5);
        check("addi_rd", {27'd0, Rd}, 32'd1);
        drive(32'h402081B3, 0, 0, 0, 0);
        check("sub_fields", {ALUControl, ALUSrc, Rs1, Rs2, Rd}, {3'b001, 1'b0, 5'd1, 5'd2, 5'd3});
        drive(32'h0020A423, 0, 0, 0, 0);
        check("sw_ctrl", {MemWrite, RegWrite, ImmSrc, ByteAddress}, {1'b1, 1'b0, 2'b01, 1'b0});
        check("sw_imm", ImmExt, 32'd8);
        drive(32'hFE208EE3, 0, 0, 0, 0);
        check("beq_ctrl", {Branch, ImmSrc, ALUControl}, {1'b1, 2'b10, 3'b001});
        check("beq_imm", ImmExt, 32'hFFFFFFFC);
        drive(32'h008000EF, 0, 0, 0, 0);
        check("jal_ctrl", {Jump, ResultSrc}, {1'b1, 2'b10});
        check("jal_imm", ImmExt, 32'd8);
        drive(32'h00008183, 0, 0, 0, 0);
        check("lb_ctrl", {ReadEnable, ResultSrc, ByteAddress}, {1'b1, 2'b01, 1'b1});

        for (int i = 0; i < 10; i++) drive(extra[i], 0, 0, 0, 0);
        drive(32'h00000037, 0, 0, 0, 0);
        check("unknown_ctrl", {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl, ImmSrc},
              13'd0);

        drive(32'h00028013, 1, 5'd5, 32'hDEADBEEF, 0);
`ifdef RF_BYPASS_EN
        check("x5_same_cycle", RD1, 32'hDEADBEEF);
`else
        check("x5_same_cycle", RD1, 32'h0);
`endif
        drive(32'h00028013, 0, 0, 0, 0);
        check("x5_next_cycle", RD1, 32'hDEADBEEF);

        drive(32'h00000013, 1, 5'd0, 32'hFFFFFFFF, 0);
        check("x0_write_same", RD1, 32'h0);
        drive(32'h00000013, 0, 0, 0, 0);
        check("x0_write_next", RD1, 32'h0);

        for (int i = 1; i < 32; i++)
            drive(rAdd(5'(i), 5'(i - 1)), 1, 5'(i), (32'(i) * 32'h01010101) ^ 32'hA5A50000, 0);
        for (int i = 0; i < 32; i++) drive(rAdd(5'(i), 5'(31 - i)), 0, 0, 0, 0);

        drive(32'h00028013, 1, 5'd5, 32'h12345678, 1);
        check("rst_bypass_blocked", RD1, 32'h05050505 ^ 32'hA5A50000);
        drive(32'h00028013, 0, 0, 0, 0);
        check("rst_clears_x5", RD1, 32'h0);
        drive(rAdd(5'd31, 5'd7), 0, 0, 0, 0);
        check("rst_clears_x31", RD1, 32'h0);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
